// File: rtl/piso_shift_register.sv
// Parallel-in, serial-out shift register: loads a WIDTH-bit word when sel=0 and
// shifts it out one bit per clock when sel=1, LSB or MSB first.
module piso_shift_register #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  input  logic             sel,
  output logic             q
);

  logic [WIDTH-1:0] sr_r;
  logic [WIDTH-1:0] sr_next_s;

  // Next-state selection: parallel load or zero-filling shift toward the output end.
  always_comb begin
    sr_next_s = sr_r;
    if (!sel) begin
      sr_next_s = d;
    end else if (MSB_FIRST) begin
      sr_next_s = {sr_r[WIDTH-2:0], 1'b0};
    end else begin
      sr_next_s = {1'b0, sr_r[WIDTH-1:1]};
    end
  end

  // Shift register with synchronous active-low clear taking priority over sel.
  always_ff @(posedge clock) begin
    if (!reset) begin
      sr_r <= {WIDTH{1'b0}};
    end else begin
      sr_r <= sr_next_s;
    end
  end

  // q taps a register bit directly, so there is no combinational path from d or sel.
  generate
    if (MSB_FIRST) begin : g_msb_out
      assign q = sr_r[WIDTH-1];
    end else begin : g_lsb_out
      assign q = sr_r[0];
    end
  endgenerate

endmodule

// File: tb/tb_piso_shift_register.sv
// Self-checking bench for piso_shift_register: directed vector table on the default
// instance, hand sequences for WIDTH=8/MSB_FIRST=1 and WIDTH=2, then random vs model.
module tb_piso_shift_register;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       r4, s4, q4;
  logic [3:0] d4;
  logic       r8, s8, q8;
  logic [7:0] d8;
  logic       r2, s2, q2;
  logic [1:0] d2;

  piso_shift_register #(.WIDTH(4), .MSB_FIRST(1'b0)) dut4 (
    .clock(clock), .reset(r4), .d(d4), .sel(s4), .q(q4));
  piso_shift_register #(.WIDTH(8), .MSB_FIRST(1'b1)) dut8 (
    .clock(clock), .reset(r8), .d(d8), .sel(s8), .q(q8));
  piso_shift_register #(.WIDTH(2), .MSB_FIRST(1'b0)) dut2 (
    .clock(clock), .reset(r2), .d(d2), .sel(s2), .q(q2));

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       rst;
    logic       sel;
    logic [3:0] d;
    logic       exp;
  } vec_t;
  vec_t tbl[$];

  typedef bit bq_t[$];
  bq_t m4, m8, m2;

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: q=%b expected %b at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic void add(input logic r, input logic s, input logic [3:0] d, input logic e);
    vec_t v;
    v.rst = r; v.sel = s; v.d = d; v.exp = e;
    tbl.push_back(v);
  endfunction

  // Reference model: the register is a queue of bits still waiting to leave, in
  // transmission order; once it is empty the output is the zero fill.
  function automatic bq_t model_step(input bq_t m, input logic r, input logic s,
                                     input logic [7:0] d, input int w, input bit msb);
    bq_t n;
    n = m;
    if (!r) begin
      n.delete();
    end else if (!s) begin
      n.delete();
      for (int i = 0; i < w; i++) n.push_back(msb ? d[w-1-i] : d[i]);
    end else if (n.size() > 0) begin
      void'(n.pop_front());
    end
    return n;
  endfunction

  function automatic logic model_q(input bq_t m);
    return (m.size() > 0) ? m[0] : 1'b0;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [7:0] exp8[$];
    logic [1:0] exp2[$];

    r4 = 1'b0; s4 = 1'b1; d4 = 4'hF;
    r8 = 1'b0; s8 = 1'b1; d8 = 8'hFF;
    r2 = 1'b0; s2 = 1'b1; d2 = 2'b11;

    // reset, then release with sel=1
    add(1'b0, 1'b1, 4'b1111, 1'b0); add(1'b0, 1'b1, 4'b1111, 1'b0);
    add(1'b1, 1'b1, 4'b1111, 1'b0);
    // load 1011 and drain, then three more zero shifts
    add(1'b1, 1'b0, 4'b1011, 1'b1); add(1'b1, 1'b1, 4'b0000, 1'b1);
    add(1'b1, 1'b1, 4'b0000, 1'b0); add(1'b1, 1'b1, 4'b0000, 1'b1);
    add(1'b1, 1'b1, 4'b0000, 1'b0); add(1'b1, 1'b1, 4'b0000, 1'b0);
    add(1'b1, 1'b1, 4'b0000, 1'b0); add(1'b1, 1'b1, 4'b0000, 1'b0);
    // back-to-back words 1011 then 0110
    add(1'b1, 1'b0, 4'b1011, 1'b1); add(1'b1, 1'b1, 4'b0000, 1'b1);
    add(1'b1, 1'b1, 4'b0000, 1'b0); add(1'b1, 1'b1, 4'b0000, 1'b1);
    add(1'b1, 1'b0, 4'b0110, 1'b0); add(1'b1, 1'b1, 4'b0000, 1'b1);
    add(1'b1, 1'b1, 4'b0000, 1'b1); add(1'b1, 1'b1, 4'b0000, 1'b0);
    // mid-stream reload with 0100
    add(1'b1, 1'b0, 4'b1011, 1'b1); add(1'b1, 1'b1, 4'b0000, 1'b1);
    add(1'b1, 1'b0, 4'b0100, 1'b0); add(1'b1, 1'b1, 4'b0000, 1'b0);
    add(1'b1, 1'b1, 4'b0000, 1'b1); add(1'b1, 1'b1, 4'b0000, 1'b0);
    // reset during the second shift
    add(1'b1, 1'b0, 4'b1011, 1'b1); add(1'b1, 1'b1, 4'b0000, 1'b1);
    add(1'b0, 1'b1, 4'b0000, 1'b0); add(1'b1, 1'b1, 4'b0000, 1'b0);
    // continuous load
    add(1'b1, 1'b0, 4'b0001, 1'b1); add(1'b1, 1'b0, 4'b0000, 1'b0);
    add(1'b1, 1'b0, 4'b0011, 1'b1);

    foreach (tbl[i]) begin
      r4 = tbl[i].rst; s4 = tbl[i].sel; d4 = tbl[i].d;
      tick();
      chk($sformatf("w4_vec%0d", i), q4, tbl[i].exp);
    end

    // WIDTH=8, MSB_FIRST=1: load 1000_0001 and shift 8 times
    r8 = 1'b1; s8 = 1'b0; d8 = 8'b1000_0001;
    tick();
    chk("w8_load", q8, 1'b1);
    exp8 = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd0};
    s8 = 1'b1; d8 = 8'h00;
    foreach (exp8[i]) begin
      tick();
      chk($sformatf("w8_shift%0d", i), q8, exp8[i][0]);
    end

    // WIDTH=2: load 10 then shift twice
    r2 = 1'b1; s2 = 1'b0; d2 = 2'b10;
    tick();
    chk("w2_load", q2, 1'b0);
    exp2 = '{2'd1, 2'd0};
    s2 = 1'b1; d2 = 2'b00;
    foreach (exp2[i]) begin
      tick();
      chk($sformatf("w2_shift%0d", i), q2, exp2[i][0]);
    end

    // random phase: synchronise models with one reset edge, then random traffic
    r4 = 1'b0; r8 = 1'b0; r2 = 1'b0;
    tick();
    m4.delete(); m8.delete(); m2.delete();
    for (int i = 0; i < 400; i++) begin
      r4 = ($urandom_range(0, 19) != 0); s4 = ($urandom_range(0, 3) != 0);
      d4 = 4'($urandom);
      r8 = ($urandom_range(0, 19) != 0); s8 = ($urandom_range(0, 5) != 0);
      d8 = 8'($urandom);
      r2 = ($urandom_range(0, 19) != 0); s2 = ($urandom_range(0, 2) != 0);
      d2 = 2'($urandom);
      tick();
      m4 = model_step(m4, r4, s4, {4'h0, d4}, 4, 1'b0);
      m8 = model_step(m8, r8, s8, d8, 8, 1'b1);
      m2 = model_step(m2, r2, s2, {6'h00, d2}, 2, 1'b0);
      chk($sformatf("rnd_w4_%0d", i), q4, model_q(m4));
      chk($sformatf("rnd_w8_%0d", i), q8, model_q(m8));
      chk($sformatf("rnd_w2_%0d", i), q2, model_q(m2));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
